ras_commit_restore: RTL and testbench

RAS_COMMIT_RESTORE -- requirements
Module: ras_commit_restore

---
 rtl/ras_commit_restore_if.sv | 42 ++++
 rtl/ras_commit_restore.sv | 144 ++++++++++++++
 tb/tb_ras_commit_restore.sv | 325 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ras_commit_restore_if.sv
// Commit/restore bundle between the retire stage, this block and the fetch-side RAS.
// Latency: n/a (wires only).
// Backpressure: restore beats use restore_valid/restore_ready; commits carry no backpressure.
// Optional stats outputs exist only when RAS_COMMIT_STATS_EN is defined.
interface ras_commit_restore_if;
    logic        commit_en;
    logic        commit_push;
    logic [16:0] commit_addr;
    logic        flush;
    logic        restore_valid;
    logic        restore_ready;
    logic [3:0]  restore_idx;
    logic [16:0] restore_addr;
    logic [3:0]  restore_ptr;
    logic        restore_last;
    logic        busy;
    logic [16:0] commit_top;
`ifdef RAS_COMMIT_STATS_EN
    logic [7:0]  ovf_cnt;
    logic [7:0]  unf_cnt;
`endif

    // Retire/flush source and fetch-side sink.
    modport master (
        output commit_en, commit_push, commit_addr, flush, restore_ready,
        input  restore_valid, restore_idx, restore_addr, restore_ptr,
               restore_last, busy, commit_top
`ifdef RAS_COMMIT_STATS_EN
        , input ovf_cnt, unf_cnt
`endif
    );

    // The committed-RAS block itself.
    modport slave (
        input  commit_en, commit_push, commit_addr, flush, restore_ready,
        output restore_valid, restore_idx, restore_addr, restore_ptr,
               restore_last, busy, commit_top
`ifdef RAS_COMMIT_STATS_EN
        , output ovf_cnt, unf_cnt
`endif
    );
endinterface

// File: rtl/ras_commit_restore.sv
// Committed return-address stack; on flush, streams all 16 entries plus pointer to fetch side.
// Latency: commit visible on commit_top next cycle; first restore beat one cycle after flush.
// Backpressure: beats held stable while restore_ready is low; commits ignored during a restore.
// Optional feature macro: RAS_COMMIT_STATS_EN (depth tracker plus ovf_cnt/unf_cnt).
module ras_commit_restore (
    input  logic                 clk,
    input  logic                 rst,
    ras_commit_restore_if.slave  bus
);

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        RESTORE = 1'b1
    } state_t;

    state_t      state;
    logic [16:0] arr [16];
    logic [3:0]  cptr;
    logic [3:0]  idx;
    logic        valid_q;
    logic        last_q;

    logic        commit_apply;
    logic [3:0]  cptr_inc;
    logic [3:0]  cptr_dec;

    // Commits only retire into the committed copy while no restore is streaming it out,
    // so a restore always ships one consistent snapshot.
    assign commit_apply = bus.commit_en && (state == IDLE);
    assign cptr_inc     = cptr + 4'd1;
    assign cptr_dec     = cptr - 4'd1;

    // Committed array: a push writes the slot the pointer is moving to.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 16; i++) begin
                arr[i] <= '0;
            end
        end else if (commit_apply && bus.commit_push) begin
            arr[cptr_inc] <= bus.commit_addr;
        end
    end

    // Committed pointer: wraps modulo 16 in both directions.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cptr <= '0;
        end else if (commit_apply) begin
            cptr <= bus.commit_push ? cptr_inc : cptr_dec;
        end
    end

    // Restore sequencer: walks idx 0..15 one accepted beat at a time; a flush restarts it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            idx     <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    idx    <= '0;
                    last_q <= 1'b0;
                    if (bus.flush) begin
                        state   <= RESTORE;
                        valid_q <= 1'b1;
                    end else begin
                        valid_q <= 1'b0;
                    end
                end
                RESTORE: begin
                    if (bus.flush) begin
                        idx    <= '0;
                        last_q <= 1'b0;
                    end else if (bus.restore_ready) begin
                        if (idx == 4'd15) begin
                            state   <= IDLE;
                            idx     <= '0;
                            valid_q <= 1'b0;
                            last_q  <= 1'b0;
                        end else begin
                            idx    <= idx + 4'd1;
                            last_q <= (idx == 4'd14);
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    idx     <= '0;
                    valid_q <= 1'b0;
                    last_q  <= 1'b0;
                end
            endcase
        end
    end

    // The array and pointer are frozen during RESTORE, so these reads hold steady
    // for as long as a beat is stalled.
    assign bus.restore_valid = valid_q;
    assign bus.busy          = valid_q;
    assign bus.restore_last  = last_q;
    assign bus.restore_idx   = idx;
    assign bus.restore_addr  = arr[idx];
    assign bus.restore_ptr   = cptr;
    assign bus.commit_top    = arr[cptr];

`ifdef RAS_COMMIT_STATS_EN
    logic [4:0] depth;
    logic [7:0] ovf_q;
    logic [7:0] unf_q;

    // Depth saturates at 0/16; pushes at full and pops at empty are counted instead.
    always_ff @(posedge clk) begin
        if (!rst) begin
            depth <= '0;
            ovf_q <= '0;
            unf_q <= '0;
        end else if (commit_apply) begin
            if (bus.commit_push) begin
                if (depth == 5'd16) begin
                    if (ovf_q != 8'hFF) begin
                        ovf_q <= ovf_q + 8'd1;
                    end
                end else begin
                    depth <= depth + 5'd1;
                end
            end else begin
                if (depth == 5'd0) begin
                    if (unf_q != 8'hFF) begin
                        unf_q <= unf_q + 8'd1;
                    end
                end else begin
                    depth <= depth - 5'd1;
                end
            end
        end
    end

    assign bus.ovf_cnt = ovf_q;
    assign bus.unf_cnt = unf_q;
`endif

endmodule

// File: tb/tb_ras_commit_restore.sv
// Bench for ras_commit_restore: snapshot-queue model checked every cycle plus directed literals.
// Latency: model updates at posedge, outputs compared at negedge, stimulus driven posedge+2.
// Backpressure: restore_ready is stalled in one scenario; honours RAS_COMMIT_STATS_EN.
module tb_ras_commit_restore;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    ras_commit_restore_if bus ();

    ras_commit_restore dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int          idx;
        logic [16:0] addr;
        int          ptr;
    } beat_t;

    typedef struct {
        int          idx;
        logic [16:0] addr;
        int          ptr;
        bit          last;
    } rec_t;

    // Model: committed contents as a plain array, a restore as a queue of the 16 beats
    // still owed (snapshot taken when the flush lands).
    logic [16:0] m_arr [16];
    int          m_cptr;
    beat_t       exp_q [$];
    bit          m_known = 1'b0;
    int          m_depth, m_ovf, m_unf;
    rec_t        log_q [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    function automatic void snap();
        exp_q.delete();
        for (int i = 0; i < 16; i++) begin
            beat_t b;
            b.idx  = i;
            b.addr = m_arr[i];
            b.ptr  = m_cptr;
            exp_q.push_back(b);
        end
    endfunction

    task automatic model_step();
        if (!rst) begin
            for (int i = 0; i < 16; i++) m_arr[i] = '0;
            m_cptr  = 0;
            m_depth = 0;
            m_ovf   = 0;
            m_unf   = 0;
            exp_q.delete();
            m_known = 1'b1;
        end else if (m_known) begin
            if (exp_q.size() == 0) begin
                if (bus.commit_en) begin
                    if (bus.commit_push) begin
                        m_cptr = (m_cptr + 1) % 16;
                        m_arr[m_cptr] = bus.commit_addr;
                        if (m_depth == 16) m_ovf = (m_ovf < 255) ? m_ovf + 1 : 255;
                        else m_depth++;
                    end else begin
                        m_cptr = (m_cptr + 15) % 16;
                        if (m_depth == 0) m_unf = (m_unf < 255) ? m_unf + 1 : 255;
                        else m_depth--;
                    end
                end
                if (bus.flush) snap();
            end else if (bus.flush) begin
                snap();
            end else if (bus.restore_ready) begin
                void'(exp_q.pop_front());
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // Per-cycle compare against the model, plus a log of accepted beats.
    initial forever begin
        @(negedge clk);
        if (m_known) begin
            chk("commit_top", 32'(bus.commit_top), 32'(m_arr[m_cptr]));
`ifdef RAS_COMMIT_STATS_EN
            chk("ovf_cnt", 32'(bus.ovf_cnt), 32'(m_ovf));
            chk("unf_cnt", 32'(bus.unf_cnt), 32'(m_unf));
`endif
            if (exp_q.size() == 0) begin
                chk("idle_valid", 32'(bus.restore_valid), 32'd0);
                chk("idle_busy", 32'(bus.busy), 32'd0);
                chk("idle_last", 32'(bus.restore_last), 32'd0);
                chk("idle_idx", 32'(bus.restore_idx), 32'd0);
            end else begin
                chk("beat_valid", 32'(bus.restore_valid), 32'd1);
                chk("beat_busy", 32'(bus.busy), 32'd1);
                chk("beat_idx", 32'(bus.restore_idx), 32'(exp_q[0].idx));
                chk("beat_addr", 32'(bus.restore_addr), 32'(exp_q[0].addr));
                chk("beat_ptr", 32'(bus.restore_ptr), 32'(exp_q[0].ptr));
                chk("beat_last", 32'(bus.restore_last), (exp_q[0].idx == 15) ? 32'd1 : 32'd0);
            end
        end
        if (rst && bus.restore_valid && bus.restore_ready) begin
            rec_t r;
            r.idx  = int'(bus.restore_idx);
            r.addr = bus.restore_addr;
            r.ptr  = int'(bus.restore_ptr);
            r.last = bus.restore_last;
            log_q.push_back(r);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic push(input logic [16:0] a);
        bus.commit_en   = 1'b1;
        bus.commit_push = 1'b1;
        bus.commit_addr = a;
        tick();
        bus.commit_en   = 1'b0;
        bus.commit_push = 1'b0;
    endtask

    task automatic pop();
        bus.commit_en   = 1'b1;
        bus.commit_push = 1'b0;
        tick();
        bus.commit_en   = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        rst = 1'b1;
    endtask

    task automatic start_flush();
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (bus.busy && n < 60) begin
            tick();
            n++;
        end
        chk(name, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        int stall;
        int n;
        bus.commit_en     = 1'b0;
        bus.commit_push   = 1'b0;
        bus.commit_addr   = '0;
        bus.flush         = 1'b0;
        bus.restore_ready = 1'b0;
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;

        // Reset values.
        chk("rst_valid", 32'(bus.restore_valid), 32'd0);
        chk("rst_idx", 32'(bus.restore_idx), 32'd0);
        chk("rst_last", 32'(bus.restore_last), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_top", 32'(bus.commit_top), 32'd0);
        chk("rst_ptr", 32'(bus.restore_ptr), 32'd0);
        chk("rst_addr", 32'(bus.restore_addr), 32'd0);

        // Push/push/pop.
        push(17'h00100);
        push(17'h00200);
        chk("pp_top", 32'(bus.commit_top), 32'h00200);
        pop();
        chk("pop_top", 32'(bus.commit_top), 32'h00100);

        // 17 pushes wrap the pointer to 1.
        do_reset();
        for (int i = 0; i <= 16; i++) push(17'(32'h1000 + i));
        chk("wrap_top", 32'(bus.commit_top), 32'h01010);
`ifdef RAS_COMMIT_STATS_EN
        chk("wrap_ovf", 32'(bus.ovf_cnt), 32'd1);
`endif
        bus.restore_ready = 1'b1;
        start_flush();
        chk("wrap_ptr", 32'(bus.restore_ptr), 32'd1);
        chk("wrap_idx0", 32'(bus.restore_idx), 32'd0);
        tick();
        chk("wrap_idx1", 32'(bus.restore_idx), 32'd1);
        chk("wrap_addr1", 32'(bus.restore_addr), 32'h01010);
        wait_idle("wrap_idle");

        // Full restore with ready tied high.
        do_reset();
        push(17'h0000A);
        push(17'h0000B);
        log_q.delete();
        start_flush();
        for (int k = 0; k < 16; k++) begin
            chk("full_valid", 32'(bus.restore_valid), 32'd1);
            chk("full_idx", 32'(bus.restore_idx), 32'(k));
            chk("full_ptr", 32'(bus.restore_ptr), 32'd2);
            chk("full_last", 32'(bus.restore_last), (k == 15) ? 32'd1 : 32'd0);
            tick();
        end
        chk("full_busy_after", 32'(bus.busy), 32'd0);
        chk("full_valid_after", 32'(bus.restore_valid), 32'd0);
        chk("full_beats", 32'(log_q.size()), 32'd16);
        if (log_q.size() == 16) chk("full_addr2", 32'(log_q[2].addr), 32'h0000B);

        // Stall at idx 5, with commits attempted mid-restore.
        push(17'h00031);
        push(17'h00032);
        push(17'h00033);
        log_q.delete();
        start_flush();
        stall = 0;
        n = 0;
        while (bus.busy && n < 60) begin
            if (bus.restore_idx == 4'd5 && stall < 3) begin
                bus.restore_ready = 1'b0;
                chk("stall_idx", 32'(bus.restore_idx), 32'd5);
                chk("stall_addr", 32'(bus.restore_addr), 32'h00033);
                stall++;
            end else begin
                bus.restore_ready = 1'b1;
            end
            bus.commit_en   = (n >= 2 && n <= 4);
            bus.commit_push = 1'b1;
            bus.commit_addr = 17'h1FFFF;
            tick();
            n++;
        end
        bus.commit_en     = 1'b0;
        bus.commit_push   = 1'b0;
        bus.restore_ready = 1'b1;
        chk("stall_done", 32'(bus.busy), 32'd0);
        chk("stall_cycles", 32'(stall), 32'd3);
        chk("stall_beats", 32'(log_q.size()), 32'd16);
        for (int i = 0; i < log_q.size() && i < 16; i++) chk("stall_seq", 32'(log_q[i].idx), 32'(i));
        chk("ignored_commit_top", 32'(bus.commit_top), 32'h00033);

        // Flush during a restore restarts at idx 0.
        start_flush();
        tick();
        tick();
        tick();
        chk("pre_reflush_idx", 32'(bus.restore_idx), 32'd3);
        start_flush();
        chk("reflush_idx", 32'(bus.restore_idx), 32'd0);
        chk("reflush_valid", 32'(bus.restore_valid), 32'd1);
        wait_idle("reflush_idle");

        // Flush together with a push: restore carries the post-commit state.
        bus.commit_en   = 1'b1;
        bus.commit_push = 1'b1;
        bus.commit_addr = 17'h0ABCD;
        bus.flush       = 1'b1;
        tick();
        bus.commit_en   = 1'b0;
        bus.commit_push = 1'b0;
        bus.flush       = 1'b0;
        chk("cf_ptr", 32'(bus.restore_ptr), 32'd6);
        for (int k = 0; k < 6; k++) tick();
        chk("cf_idx", 32'(bus.restore_idx), 32'd6);
        chk("cf_addr", 32'(bus.restore_addr), 32'h0ABCD);
        wait_idle("cf_idle");

        // Reset in the middle of a restore.
        start_flush();
        for (int k = 0; k < 8; k++) tick();
        chk("mid_idx", 32'(bus.restore_idx), 32'd8);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        chk("abort_valid", 32'(bus.restore_valid), 32'd0);
        chk("abort_top", 32'(bus.commit_top), 32'd0);
        log_q.delete();
        for (int k = 0; k < 5; k++) tick();
        chk("abort_no_beats", 32'(log_q.size()), 32'd0);
        chk("abort_busy", 32'(bus.busy), 32'd0);
        pop();
`ifdef RAS_COMMIT_STATS_EN
        chk("abort_unf", 32'(bus.unf_cnt), 32'd1);
`endif
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
